state_transition_monitor: RTL

- Consumer stage placed directly downstream of the set-reset flip-flop; samples its `state` output in the same clock domain.
- Produces single-cycle edge pulses, saturating rise/fall event counters and high-period duration measurement.
- Provides a sticky interrupt flag, so software or control logic can observe flag activity without polling every cycle.

---
 rtl/state_transition_monitor_if.sv | 43 ++++
 rtl/state_transition_monitor.sv | 130 +++++++++++++
 2 files changed

// File: rtl/state_transition_monitor_if.sv
// Bundles the flag level, control inputs and measurement outputs of the
// state transition monitor; master drives state/controls, slave is the monitor.
interface state_transition_monitor_if #(
    parameter int unsigned COUNTER_WIDTH  = 8,
    parameter int unsigned DURATION_WIDTH = 16
);
    logic                      state;
    logic                      clear;
    logic                      interrupt_acknowledge;
    logic                      rising_pulse;
    logic                      falling_pulse;
    logic [COUNTER_WIDTH-1:0]  rising_count;
    logic [COUNTER_WIDTH-1:0]  falling_count;
    logic [DURATION_WIDTH-1:0] high_duration;
    logic [DURATION_WIDTH-1:0] last_high_duration;
    logic                      interrupt;

    modport master (
        output state,
        output clear,
        output interrupt_acknowledge,
        input  rising_pulse,
        input  falling_pulse,
        input  rising_count,
        input  falling_count,
        input  high_duration,
        input  last_high_duration,
        input  interrupt
    );

    modport slave (
        input  state,
        input  clear,
        input  interrupt_acknowledge,
        output rising_pulse,
        output falling_pulse,
        output rising_count,
        output falling_count,
        output high_duration,
        output last_high_duration,
        output interrupt
    );
endinterface

// File: rtl/state_transition_monitor.sv
// Watches the set-reset flag level: registered edge pulses, saturating edge
// counters, high-period duration measurement and a sticky interrupt.
module state_transition_monitor #(
    parameter int unsigned COUNTER_WIDTH  = 8,
    parameter int unsigned DURATION_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    state_transition_monitor_if.slave    monitor_bus
);
    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } fsm_state_t;

    localparam logic [COUNTER_WIDTH-1:0]  COUNT_ONE    = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0]  COUNT_MAX    = '1;
    localparam logic [DURATION_WIDTH-1:0] DURATION_ONE = DURATION_WIDTH'(1);
    localparam logic [DURATION_WIDTH-1:0] DURATION_MAX = '1;

    fsm_state_t                fsm_q, fsm_d;
    logic                      rise, fall;

    logic                      rising_pulse_q, rising_pulse_d;
    logic                      falling_pulse_q, falling_pulse_d;
    logic [COUNTER_WIDTH-1:0]  rising_count_q, rising_count_d;
    logic [COUNTER_WIDTH-1:0]  falling_count_q, falling_count_d;
    logic [DURATION_WIDTH-1:0] high_duration_q, high_duration_d;
    logic [DURATION_WIDTH-1:0] last_high_duration_q, last_high_duration_d;
    logic                      interrupt_q, interrupt_d;

    // The FSM register is also the previous-state sample used for edge detection.
    always_comb begin
        fsm_d = fsm_q;
        rise  = 1'b0;
        fall  = 1'b0;
        case (fsm_q)
            LOW: begin
                if (monitor_bus.state) begin
                    fsm_d = HIGH;
                    rise  = 1'b1;
                end
            end
            HIGH: begin
                if (!monitor_bus.state) begin
                    fsm_d = LOW;
                    fall  = 1'b1;
                end
            end
            default: fsm_d = LOW;
        endcase
    end

    always_comb begin
        rising_pulse_d       = rise;
        falling_pulse_d      = fall;
        rising_count_d       = rising_count_q;
        falling_count_d      = falling_count_q;
        high_duration_d      = high_duration_q;
        last_high_duration_d = last_high_duration_q;
        interrupt_d          = interrupt_q;

        if (monitor_bus.clear) begin
            rising_count_d  = '0;
            falling_count_d = '0;
        end else begin
            if (rise && rising_count_q != COUNT_MAX) begin
                rising_count_d = rising_count_q + COUNT_ONE;
            end
            if (fall && falling_count_q != COUNT_MAX) begin
                falling_count_d = falling_count_q + COUNT_ONE;
            end
        end

        // Clear restarts an in-progress measurement rather than abandoning it.
        if (monitor_bus.clear) begin
            high_duration_d = monitor_bus.state ? DURATION_ONE : '0;
        end else if (rise) begin
            high_duration_d = DURATION_ONE;
        end else if (fall) begin
            high_duration_d = '0;
        end else if (fsm_q == HIGH && high_duration_q != DURATION_MAX) begin
            high_duration_d = high_duration_q + DURATION_ONE;
        end

        if (monitor_bus.clear) begin
            last_high_duration_d = '0;
        end else if (fall) begin
            last_high_duration_d = high_duration_q;
        end

        if (monitor_bus.clear) begin
            interrupt_d = 1'b0;
        end else if (rise) begin
            interrupt_d = 1'b1;
        end else if (monitor_bus.interrupt_acknowledge) begin
            interrupt_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q                <= LOW;
            rising_pulse_q       <= 1'b0;
            falling_pulse_q      <= 1'b0;
            rising_count_q       <= '0;
            falling_count_q      <= '0;
            high_duration_q      <= '0;
            last_high_duration_q <= '0;
            interrupt_q          <= 1'b0;
        end else begin
            fsm_q                <= fsm_d;
            rising_pulse_q       <= rising_pulse_d;
            falling_pulse_q      <= falling_pulse_d;
            rising_count_q       <= rising_count_d;
            falling_count_q      <= falling_count_d;
            high_duration_q      <= high_duration_d;
            last_high_duration_q <= last_high_duration_d;
            interrupt_q          <= interrupt_d;
        end
    end

    assign monitor_bus.rising_pulse       = rising_pulse_q;
    assign monitor_bus.falling_pulse      = falling_pulse_q;
    assign monitor_bus.rising_count       = rising_count_q;
    assign monitor_bus.falling_count      = falling_count_q;
    assign monitor_bus.high_duration      = high_duration_q;
    assign monitor_bus.last_high_duration = last_high_duration_q;
    assign monitor_bus.interrupt          = interrupt_q;
endmodule
